// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Register-dependency scoreboard for the in-order pipelined core. Each
// post-decode stage (entry 0 = EX, youngest ... entry STAGES-1 = WB, oldest)
// keeps a destination record {valid, wen, wsel, is_load}. The decode slot's
// sources are compared against every record to produce the decode stall
// (hold PC and IF/ID, insert a bubble) and, optionally, forwarding selects.
//
// Build option:
//   FORWARD_PATH_EN  defined   -> forwarding selects are driven; only a
//                                 load-use on entry 0 stalls.
//                    undefined -> selects tied to 0; any match stalls.
//
// Ports:
//   CLK, nRST                  clock, asynchronous active-low reset
//   advance                    pipeline enable; records shift only when high
//   dec_valid .. dec_is_load   decode-slot instruction description
//   flush_dec                  squash the decode slot
//   flush_mask[STAGES]         squash entry i (pre-shift)
//   stall                      combinational decode stall / bubble request
//   fwd_rs_sel, fwd_rt_sel     0 = register file, k = forward from entry k-1
//   inflight, busy             registered count of valid writers, != 0 flag
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int STAGES = 3,
    parameter int REG_W  = 5,
    parameter int SEL_W  = $clog2(STAGES + 1)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              advance,
    input  logic              dec_valid,
    input  logic [REG_W-1:0]  dec_rs,
    input  logic [REG_W-1:0]  dec_rt,
    input  logic              dec_use_rs,
    input  logic              dec_use_rt,
    input  logic              dec_wen,
    input  logic [REG_W-1:0]  dec_wsel,
    input  logic              dec_is_load,
    input  logic              flush_dec,
    input  logic [STAGES-1:0] flush_mask,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic [SEL_W-1:0]  inflight,
    output logic              busy
);

    typedef struct packed {
        logic             valid;
        logic             wen;
        logic [REG_W-1:0] wsel;
        logic             is_load;
    } entry_t;

    entry_t             ent_q [STAGES];
    entry_t             ent_d [STAGES];
    logic [SEL_W-1:0]   inflight_q, inflight_d;
    logic               busy_q;
    logic [STAGES-1:0]  hit_rs, hit_rt;

    // Register 0 is hardwired, so a write to it never produces a hazard.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            hit_rs[i] = dec_valid & dec_use_rs & ent_q[i].valid & ent_q[i].wen &
                        (ent_q[i].wsel != '0) & (ent_q[i].wsel == dec_rs);
            hit_rt[i] = dec_valid & dec_use_rt & ent_q[i].valid & ent_q[i].wen &
                        (ent_q[i].wsel != '0) & (ent_q[i].wsel == dec_rt);
        end
    end

`ifdef FORWARD_PATH_EN
    logic [SEL_W-1:0] rs_sel, rt_sel;

    // Scan oldest to youngest so the youngest duplicate destination wins.
    always_comb begin
        rs_sel = '0;
        rt_sel = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (hit_rs[i]) rs_sel = SEL_W'(i + 1);
            if (hit_rt[i]) rt_sel = SEL_W'(i + 1);
        end
    end

    // Only a load still in EX cannot be forwarded; everything else bypasses.
    assign stall      = ~flush_dec & ent_q[0].is_load & (hit_rs[0] | hit_rt[0]);
    assign fwd_rs_sel = rs_sel;
    assign fwd_rt_sel = rt_sel;
`else
    assign stall      = ~flush_dec & ((|hit_rs) | (|hit_rt));
    assign fwd_rs_sel = '0;
    assign fwd_rt_sel = '0;
`endif

    // Squash is applied to the pre-shift records, so a squashed instruction
    // keeps moving down the pipe as a bubble.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            ent_d[i]       = ent_q[i];
            ent_d[i].valid = ent_q[i].valid & ~flush_mask[i];
        end
        if (advance) begin
            for (int i = STAGES - 1; i > 0; i--) begin
                ent_d[i] = ent_d[i-1];
            end
            if (dec_valid & ~flush_dec & ~stall) begin
                ent_d[0].valid   = 1'b1;
                ent_d[0].wen     = dec_wen;
                ent_d[0].wsel    = dec_wsel;
                ent_d[0].is_load = dec_is_load;
            end else begin
                ent_d[0] = '0;
            end
        end
        inflight_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (ent_d[i].valid & ent_d[i].wen) inflight_d = inflight_d + SEL_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < STAGES; i++) ent_q[i] <= '0;
            inflight_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            for (int i = 0; i < STAGES; i++) ent_q[i] <= ent_d[i];
            inflight_q <= inflight_d;
            busy_q     <= (inflight_d != '0);
        end
    end

    assign inflight = inflight_q;
    assign busy     = busy_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised register-dependency scoreboard for the in-order pipelined core.
- Tracks in-flight register writes across a configurable number of post-decode stages (EX, MEM, WB by default).
- Drives the decode stall and the bubble-insert request.
- Replaces ad-hoc opcode-class hazard comparisons with a uniform per-stage destination record; optionally emits forwarding selects.

Parameters:
STAGES, 3, number of tracked post-decode stages; entry 0 = youngest (EX), entry STAGES-1 = oldest (WB)
REG_W, 5, register index width
SEL_W, $clog2(STAGES+1), width of forwarding select

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
advance  input  1  pipeline enable (ihit|dhit); entries shift only when high
dec_valid  input  1  decode slot holds a real instruction
dec_rs  input  REG_W  decode source register A
dec_rt  input  REG_W  decode source register B
dec_use_rs  input  1  decode instruction reads rs
dec_use_rt  input  1  decode instruction reads rt
dec_wen  input  1  decode instruction writes a register
dec_wsel  input  REG_W  decode destination (rd/rt/31 already resolved)
dec_is_load  input  1  decode instruction is a load
flush_dec  input  1  squash decode slot (branch/jump taken)
flush_mask  input  STAGES  per-entry squash, bit i clears entry i
stall  output  1  hold PC and IF/ID; insert bubble
fwd_rs_sel  output  SEL_W  0 = register file, k = forward from entry k-1
fwd_rt_sel  output  SEL_W  as above for rt
inflight  output  SEL_W  count of valid writing entries
busy  output  1  inflight != 0

Behaviour:
- Each entry holds {valid, wen, wsel, is_load}. Reset: all fields 0, so stall=0, fwd_*_sel=0, inflight=0, busy=0.
- An entry is a producer when valid & wen & wsel != 0. Register 0 never creates a hazard.
- Source match for rs: dec_valid & dec_use_rs & producer(i) & wsel(i)==dec_rs. Same rule for rt.
- stall (combinational, base build): any rs or rt match in any entry, and flush_dec=0. A flushed decode slot never stalls.
- Edge with advance=1:
  - entry[i+1] <= entry[i] with valid cleared if flush_mask[i].
  - The oldest entry retires.
  - entry[0] <= decode record if dec_valid & !flush_dec & !stall; otherwise a bubble (valid=0).
- Edge with advance=0: no shift. entry[i].valid cleared where flush_mask[i]=1. The decode record is not captured.
- Simultaneous flush_mask and advance: squash applies to the pre-shift entry, so the squashed instruction moves as a bubble.
- Duplicate destinations in several entries: youngest matching entry (lowest index) determines the forwarding select.
- inflight and busy are registered, updated on the same edge as the entries, and consistent with the new entry contents.
- nRST low mid-operation clears every entry immediately; outputs go to their reset values asynchronously.
- Latency: stall responds in the same cycle as the decode inputs. A dependency clears in the cycle after the producer retires from entry STAGES-1.

Optional Feature:
- Macro FORWARD_PATH_EN.
- Defined:
  - fwd_rs_sel and fwd_rt_sel = 1 + index of the youngest matching producer, else 0.
  - stall asserted only for load-use: a match in entry 0 whose is_load=1.
  - A match in entry 0 with is_load=0, or in any older entry, forwards without stalling.
  - A match on a load in entry k>0 forwards (MEM data available).
- Undefined:
  - fwd_*_sel tied to 0.
  - stall on any match, as in the base rule.

Test Plan:
- Reset with advance=1, decode add r3,r1,r2 (wen, wsel=3) -> stall=0, entry0 captures wsel=3, inflight=1 next cycle.
- Decode next instruction reading r3 with r3 in entry0:
  - Base build -> stall=1 for 3 advancing cycles, bubbles inserted, stall=0 once r3 retires, inflight falls 1->0.
- FORWARD_PATH_EN, r3 in entry0 from add, consumer reads rs=r3 -> stall=0, fwd_rs_sel=1.
- FORWARD_PATH_EN, lw r4 in entry0, consumer reads rt=r4 -> stall=1 for one cycle, then fwd_rt_sel=2, stall=0.
- Write to r0 in every entry, consumer reads r0 -> stall=0, fwd_*_sel=0.
- Dependency on entry1 (r5), flush_mask=3'b010 with advance=1 -> entry2 valid=0, stall drops next cycle. flush_dec=1 with a matching decode -> stall=0, entry0 gets a bubble.
- nRST pulsed low mid-stall with 3 valid entries -> stall=0, inflight=0, busy=0 immediately.
